// File: rtl/ser_par_tx.sv
// ser_par_tx: parallel-in, serial-out transmitter that appends a parity bit to
// each WIDTH-bit word. Words are sent LSB first, one bit per clk. A new word can
// be accepted in the parity cycle, so frames can follow each other with no gap.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | no frame in flight, outputs quiet, ready for a word
//   SHIFT  | ser_out carries data bit cnt_q of the current word, not ready
//   PARITY | ser_out carries the parity bit, ready for the next word
module ser_par_tx #(
    parameter int   WIDTH = 8,
    parameter logic ODD   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             par_slot,
    output logic             frame_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             acc_q, acc_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             par_slot_q, par_slot_d;
    logic             frame_done_q, frame_done_d;
    logic             accept;

    // The parity cycle is already the last cycle of the frame, so a new word can
    // be taken there without opening a gap in the bitstream.
    assign ready  = (state_q != SHIFT);
    assign accept = load && ready;

    // Register every piece of state; synchronous active-low reset aborts any frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            acc_q        <= 1'b0;
            ser_out_q    <= 1'b0;
            ser_valid_q  <= 1'b0;
            par_slot_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            par_slot_q   <= par_slot_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next state and next registered outputs. The output registers are loaded with
    // the bit that will be on the line during the state being entered, so bit 0
    // appears the cycle after acceptance and acc_q always covers the bit on the line.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        ser_out_d    = 1'b0;
        ser_valid_d  = 1'b0;
        par_slot_d   = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE, PARITY: begin
                if (accept) begin
                    state_d     = SHIFT;
                    shift_d     = data_in >> 1;
                    cnt_d       = '0;
                    acc_d       = data_in[0];
                    ser_out_d   = data_in[0];
                    ser_valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                ser_valid_d = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d      = PARITY;
                    ser_out_d    = acc_q ^ ODD;
                    par_slot_d   = 1'b1;
                    frame_done_d = 1'b1;
                end else begin
                    ser_out_d = shift_q[0];
                    shift_d   = shift_q >> 1;
                    acc_d     = acc_q ^ shift_q[0];
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ser_out    = ser_out_q;
    assign ser_valid  = ser_valid_q;
    assign par_slot   = par_slot_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/ser_par_tx.md
Name: ser_par_tx

Overview:
Upstream neighbour of the serial parity checker. Accepts a parallel word through a valid/ready handshake and shifts it out LSB first on a single serial line. It then appends one generated parity bit, so the downstream checker sees a continuous bitstream of data-plus-parity frames. One bit is shifted per clk cycle, and back-to-back frames are supported with no idle gap.

Parameters:
WIDTH, 8, data bits per frame (2..32)
ODD, 0, parity sense: 0 = even parity, 1 = odd parity

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
data_in  input  WIDTH  parallel word to transmit
load  input  1  data_in valid; transfer occurs on rising clk when load=1 and ready=1
ready  output  1  block can accept a word this cycle (decoded from state)
ser_out  output  1  serial data/parity bit (registered)
ser_valid  output  1  ser_out carries a frame bit this cycle (registered)
par_slot  output  1  ser_out is the parity bit of the frame (registered)
frame_done  output  1  one-cycle pulse, coincident with par_slot (registered)

Behaviour:
- States: IDLE, SHIFT, PARITY. Internal regs: shift register (WIDTH), bit counter ($clog2(WIDTH) bits), parity accumulator (1 bit).
- Reset, when rst=0 at a clk edge:
  - state=IDLE; ser_out=0, ser_valid=0, par_slot=0, frame_done=0; shift reg, counter and accumulator cleared.
  - Reset has priority over load and aborts any frame in progress mid-bit; no parity bit is emitted for the aborted frame.
- ready = 1 in IDLE and in PARITY, 0 in SHIFT. While rst=0 at an edge, load is ignored.
- IDLE:
  - ser_valid=0, ser_out=0.
  - On load&ready: latch data_in, go to SHIFT.
  - ser_out=data_in[0] with ser_valid=1 starting the next cycle, so latency is 1 clk from the accepting edge to the first bit.
- SHIFT:
  - Each cycle outputs the next bit LSB first; the accumulator XORs each emitted bit.
  - After WIDTH data bits, go to PARITY.
  - load during SHIFT is ignored (ready=0) and data_in is not sampled.
- PARITY:
  - One cycle with ser_out = acc XOR ODD (even: total ones incl. parity even; odd: total odd).
  - ser_valid=1, par_slot=1, frame_done=1.
- Exit from PARITY:
  - If load&ready at the edge ending PARITY, latch the new word and go to SHIFT; bit 0 of the new frame follows the parity bit with no gap.
  - Otherwise go to IDLE.
- Frame length is exactly WIDTH+1 cycles of ser_valid=1. The bit counter wraps to 0 at each new frame.
- data_in changes after acceptance have no effect on the frame in flight.
- par_slot and frame_done are never 1 outside PARITY. ser_valid=0 only in IDLE.

Test Plan:
- Reset then single frame, WIDTH=8, ODD=0: hold rst=0 for 2 cycles, then rst=1, load 8'hA5 for 1 cycle -> ser_out sequence 1,0,1,0,0,1,0,1 then parity 0. ser_valid high 9 cycles, par_slot/frame_done high only on cycle 9, ready low on cycles 1-8.
- Odd-ones word, ODD=0: load 8'h07 -> bits 1,1,1,0,0,0,0,0 then parity 1. Rerun with ODD=1 and 8'hA5 -> parity bit 1.
- Back-to-back: hold load=1 with 8'hA5 then 8'h07 presented in the PARITY cycle -> 18 consecutive ser_valid cycles, parity bits 0 then 1, no idle cycle between frames.
- Load while busy: pulse load with 8'hFF during SHIFT bit 3 of an 8'h00 frame -> ignored. Frame stays all 0s with parity 0, and the block returns to IDLE afterwards.
- Reset mid-frame: drive rst=0 during bit 4 of 8'hA5 -> next cycle all outputs 0, ready=1, no parity bit. A subsequent load of 8'h01 transmits 1,0,0,0,0,0,0,0 then parity 1.
- Loopback: connect ser_out to the downstream parity checker input for 16 random words. The checker must agree with par_slot-cycle parity on every frame.
